// File: rtl/demux_eight_tdm_if.sv
// Serial TDM link bundle between the link driver (master) and demux_eight_tdm (slave).
// Carries the serial slot stream in and the published parallel frame and status flags out.
interface demux_eight_tdm_if;
    logic       din;
    logic       din_valid;
    logic       sync;
    logic [7:0] o;
    logic       frame_valid;
    logic [3:0] slot;
    logic       sync_err;
    logic       parity_err;

    modport master (
        output din,
        output din_valid,
        output sync,
        input  o,
        input  frame_valid,
        input  slot,
        input  sync_err,
        input  parity_err
    );

    modport slave (
        input  din,
        input  din_valid,
        input  sync,
        output o,
        output frame_valid,
        output slot,
        output sync_err,
        output parity_err
    );
endinterface

// File: rtl/demux_eight_tdm.sv
// Sequential 1-to-8 TDM demultiplexer: gathers serial slot bits into a frame and publishes it.
// Define DEMUX_PARITY_EN for a 9-slot frame whose last slot is an even-parity bit.
module demux_eight_tdm #(
    parameter int unsigned IDLE_TIMEOUT = 16
) (
    input logic            clk,
    input logic            rst_n,
    demux_eight_tdm_if.slave link_io
);

`ifdef DEMUX_PARITY_EN
    localparam int unsigned SlotW    = 4;
    localparam int unsigned LastSlot = 8;
`else
    localparam int unsigned SlotW    = 3;
    localparam int unsigned LastSlot = 7;
`endif
    localparam int unsigned CntW = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRecv = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [SlotW-1:0] slot_q, slot_d;
    logic [7:0]      shadow_q, shadow_d, shadow_nx;
    logic [7:0]      o_q, o_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            fv_q, fv_d;
    logic            serr_q, serr_d;
`ifdef DEMUX_PARITY_EN
    logic            perr_q, perr_d;
`endif

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        shadow_d  = shadow_q;
        cnt_d     = cnt_q;
        o_d       = o_q;
        fv_d      = 1'b0;
        serr_d    = 1'b0;
`ifdef DEMUX_PARITY_EN
        perr_d    = 1'b0;
`endif
        shadow_nx = shadow_q;
        shadow_nx[slot_q[2:0]] = link_io.din;
        cnt_inc   = cnt_q + CntW'(1);

        case (state_q)
            StIdle: begin
                if (link_io.din_valid && link_io.sync) begin
                    state_d  = StRecv;
                    shadow_d = {7'b0, link_io.din};
                    slot_d   = SlotW'(1);
                    cnt_d    = '0;
                end
            end
            StRecv: begin
                if (link_io.din_valid) begin
                    cnt_d = '0;
                    if (link_io.sync && (slot_q != '0)) begin
                        // Resynchronise: this bit starts a fresh frame.
                        serr_d   = 1'b1;
                        shadow_d = {7'b0, link_io.din};
                        slot_d   = SlotW'(1);
                    end else if (slot_q == SlotW'(LastSlot)) begin
                        fv_d   = 1'b1;
                        slot_d = '0;
`ifdef DEMUX_PARITY_EN
                        o_d    = shadow_q;
                        perr_d = ^{shadow_q, link_io.din};
`else
                        o_d    = shadow_nx;
`endif
                    end else begin
                        shadow_d = shadow_nx;
                        slot_d   = slot_q + SlotW'(1);
                    end
                end else if (cnt_inc == CntW'(IDLE_TIMEOUT)) begin
                    state_d  = StIdle;
                    slot_d   = '0;
                    cnt_d    = '0;
                    shadow_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            slot_q   <= '0;
            shadow_q <= '0;
            o_q      <= '0;
            cnt_q    <= '0;
            fv_q     <= 1'b0;
            serr_q   <= 1'b0;
`ifdef DEMUX_PARITY_EN
            perr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            o_q      <= o_d;
            cnt_q    <= cnt_d;
            fv_q     <= fv_d;
            serr_q   <= serr_d;
`ifdef DEMUX_PARITY_EN
            perr_q   <= perr_d;
`endif
        end
    end

    assign link_io.o           = o_q;
    assign link_io.frame_valid = fv_q;
    assign link_io.sync_err    = serr_q;
`ifdef DEMUX_PARITY_EN
    assign link_io.slot        = slot_q;
    assign link_io.parity_err  = perr_q;
`else
    assign link_io.slot        = {1'b0, slot_q};
    assign link_io.parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_demux_eight_tdm.sv
// Bench for demux_eight_tdm: directed scenarios plus random traffic against a queue-based model.
// Define DEMUX_PARITY_EN to exercise the 9-slot parity frame.
module tb_demux_eight_tdm;

`ifdef DEMUX_PARITY_EN
    localparam int NSLOT = 9;
`else
    localparam int NSLOT = 8;
`endif
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux_eight_tdm_if link ();

    demux_eight_tdm #(.IDLE_TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .link_io (link)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: a frame is just the list of bits gathered so far.
    bit         m_run;
    bit         m_bits[$];
    int         m_idle;
    logic [7:0] m_o;
    logic       m_fv, m_serr, m_perr;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_bits.delete();
        m_idle = 0;
        m_o = 8'h00;
        m_fv = 1'b0;
        m_serr = 1'b0;
        m_perr = 1'b0;
    endtask

    task automatic model_step(input logic d, input logic v, input logic s);
        logic [7:0] data;
        m_fv = 1'b0;
        m_serr = 1'b0;
        m_perr = 1'b0;
        if (!m_run) begin
            if (v && s) begin
                m_run = 1'b1;
                m_idle = 0;
                m_bits.delete();
                m_bits.push_back(d);
            end
        end else if (v) begin
            m_idle = 0;
            if (s && m_bits.size() != 0) begin
                m_serr = 1'b1;
                m_bits.delete();
                m_bits.push_back(d);
            end else begin
                m_bits.push_back(d);
                if (m_bits.size() == NSLOT) begin
                    for (int k = 0; k < 8; k++) data[k] = m_bits[k];
                    m_o = data;
                    m_fv = 1'b1;
                    if (NSLOT == 9) m_perr = (^data) ^ m_bits[NSLOT-1];
                    m_bits.delete();
                end
            end
        end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_run = 1'b0;
                m_bits.delete();
                m_idle = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("o", link.o, m_o);
            check("frame_valid", {7'b0, link.frame_valid}, {7'b0, m_fv});
            check("slot", {4'b0, link.slot}, 8'(m_bits.size()));
            check("sync_err", {7'b0, link.sync_err}, {7'b0, m_serr});
            check("parity_err", {7'b0, link.parity_err}, {7'b0, m_perr});
        end
    end

    task automatic cyc(input logic d, input logic v, input logic s);
        @(negedge clk);
        link.din = d;
        link.din_valid = v;
        link.sync = s;
        @(posedge clk);
        model_step(d, v, s);
        #1;
    endtask

    // Sends one full frame; parity slot (if any) carries par ^ even parity.
    task automatic send_frame(input logic [7:0] data, input bit with_sync, input logic par);
        for (int k = 0; k < 8; k++) cyc(data[k], 1'b1, (k == 0) && with_sync);
        if (NSLOT == 9) cyc((^data) ^ par, 1'b1, 1'b0);
    endtask

    task automatic pin(input string name, input logic [7:0] act, input logic [7:0] exp);
        check(name, act, exp);
    endtask

    int gap;

    initial begin
        link.din = 1'b0;
        link.din_valid = 1'b0;
        link.sync = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        pin("rst_o", link.o, 8'h00);
        pin("rst_slot", {4'b0, link.slot}, 8'h00);
        pin("rst_fv", {7'b0, link.frame_valid}, 8'h00);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Frame 0x55 then back-to-back 0xFF without sync.
        send_frame(8'h55, 1'b1, 1'b0);
        pin("f55_o", link.o, 8'h55);
        pin("f55_fv", {7'b0, link.frame_valid}, 8'h01);
        pin("f55_slot", {4'b0, link.slot}, 8'h00);
        for (int k = 0; k < NSLOT - 1; k++) cyc(1'b1, 1'b1, 1'b0);
        pin("gap_fv", {7'b0, link.frame_valid}, 8'h00);
        pin("gap_o", link.o, 8'h55);
        cyc((NSLOT == 9) ? 1'b0 : 1'b1, 1'b1, 1'b0);
        pin("fff_o", link.o, 8'hFF);
        pin("fff_fv", {7'b0, link.frame_valid}, 8'h01);

        // Sync at slot 3 restarts the frame.
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        pin("serr", {7'b0, link.sync_err}, 8'h01);
        pin("serr_slot", {4'b0, link.slot}, 8'h01);
        pin("serr_o", link.o, 8'hFF);
        for (int k = 1; k < 8; k++) cyc(k[0], 1'b1, 1'b0);
        if (NSLOT == 9) cyc(1'b0, 1'b1, 1'b0);
        pin("restart_o", link.o, 8'hAB);

        // 15 idle cycles mid-frame, then resume.
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, k == 0);
        repeat (TIMEOUT - 1) cyc(1'b0, 1'b0, 1'b0);
        pin("idle15_slot", {4'b0, link.slot}, 8'h05);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        if (NSLOT == 9) cyc(1'b1, 1'b1, 1'b0);
        pin("idle15_o", link.o, 8'hE0);

        // 16 idle cycles abort; unsynced bits in IDLE are ignored.
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, k == 0);
        repeat (TIMEOUT) cyc(1'b0, 1'b0, 1'b0);
        pin("to_slot", {4'b0, link.slot}, 8'h00);
        repeat (4) cyc(1'b1, 1'b1, 1'b0);
        pin("idle_ign_slot", {4'b0, link.slot}, 8'h00);
        pin("idle_ign_o", link.o, 8'hE0);

`ifdef DEMUX_PARITY_EN
        send_frame(8'h55, 1'b1, 1'b0);
        pin("par_ok", {7'b0, link.parity_err}, 8'h00);
        send_frame(8'h55, 1'b0, 1'b1);
        pin("par_bad", {7'b0, link.parity_err}, 8'h01);
        pin("par_bad_o", link.o, 8'h55);
`endif

        // Asynchronous reset at slot 5.
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, k == 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        pin("arst_o", link.o, 8'h00);
        pin("arst_slot", {4'b0, link.slot}, 8'h00);
        pin("arst_fv", {7'b0, link.frame_valid}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        pin("arst_idle", {4'b0, link.slot}, 8'h00);

        // Random traffic with occasional long gaps.
        gap = 0;
        for (int i = 0; i < 3000; i++) begin
            if (gap > 0) begin
                cyc(1'($urandom), 1'b0, 1'($urandom));
                gap--;
            end else if ($urandom_range(0, 99) < 2) begin
                gap = $urandom_range(10, 20);
            end else begin
                cyc(1'($urandom), $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 6);
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
